// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared states and sizing constants for the instruction-memory loader
package im_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int IM_DEPTH       = 1024;
  localparam int IM_AW          = 10;
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - download byte stream plus instruction-memory write port
interface im_loader_if
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = IM_AW
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  // loader side
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );

  // host stream source and memory sink side
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );

endinterface

// File: rtl/im_loader_byte_packer.sv
// rtl/im_loader_byte_packer.sv - shifts stream bytes MSB-first into a 32-bit word
module byte_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clr) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_en) begin
      shift_d = {shift_q[23:0], byte_in};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // Pulses with the last byte; the complete word sits in shift_q on the next cycle.
  assign word_valid = byte_en && (idx_q == 2'(BYTES_PER_WORD - 1));
  assign word       = shift_q;

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - download FSM: length header, word writes, done/err and CPU hold
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W    = IM_AW,
  parameter int MAX_WORDS = IM_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  im_loader_if.slave      bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] word_cnt,
  output logic            cpu_hold
);

  localparam int               HDR_W = 8 * HDR_BYTES;
  localparam logic [HDR_W-1:0] MAX_N = HDR_W'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              xfer;
  logic              pk_clr;
  logic              pk_en;
  logic              pk_valid;
  logic [31:0]       pk_word;
  logic [HDR_W-1:0]  hdr_n;
  logic              hdr_ok;
  logic              last_word;

  assign busy      = state_q inside {S_HDR0, S_HDR1, S_DATA, S_CHK};
  assign xfer      = bus.in_valid && busy;
  assign pk_en     = xfer && (state_q == S_DATA);
  assign pk_clr    = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign hdr_n     = {hdr_hi_q, bus.in_data};
  assign hdr_ok    = (hdr_n != '0) && (hdr_n <= MAX_N);
  assign last_word = ((word_cnt_q + (ADDR_W+1)'(1)) == n_q);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (pk_clr),
    .byte_en    (pk_en),
    .byte_in    (bus.in_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_comb begin
    state_d    = state_q;
    hdr_hi_d   = hdr_hi_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
`ifdef IM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR0;
          word_cnt_d = '0;
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_HDR0: begin
        if (xfer) begin
          hdr_hi_d = bus.in_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          // Truncation is safe: hdr_ok bounds N by MAX_WORDS.
          n_d     = hdr_n[ADDR_W:0];
          state_d = hdr_ok ? S_DATA : S_ERR;
        end
      end
      S_DATA: begin
        if (xfer) begin
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          if (pk_valid) begin
            im_we_d    = 1'b1;
            im_addr_d  = word_cnt_q[ADDR_W-1:0];
            word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
            if (last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hdr_hi_q   <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hdr_hi_q   <= hdr_hi_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.in_ready = busy;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = pk_word;
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign cpu_hold     = (state_q != S_DONE);
  assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - randomized self-checking bench for im_loader
module tb_im_loader;
  import im_loader_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           busy, done, err, cpu_hold;
  logic [IM_AW:0] word_cnt;
  int             checks = 0;
  int             errors = 0;

  im_loader_if #(.ADDR_W(IM_AW)) bus ();

  im_loader #(.ADDR_W(IM_AW), .MAX_WORDS(IM_DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IM_AW-1:0] addr;
    logic [31:0]      data;
  } wr_t;

  wr_t caps[$];

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) caps.push_back('{addr: bus.im_addr, data: bus.im_wdata});
  end

  // Reference: word i is bytes 4i..4i+3 weighted big-endian.
  function automatic void model_words(input logic [7:0] pay[$], output logic [31:0] w[$]);
    w = {};
    for (int i = 0; i < pay.size() / 4; i++)
      w.push_back(pay[4*i] * 32'h0100_0000 + pay[4*i+1] * 32'h0001_0000
                  + pay[4*i+2] * 32'h0000_0100 + 32'(pay[4*i+3]));
  endfunction

  function automatic logic [7:0] model_csum(input logic [7:0] pay[$]);
    logic [7:0] c = 8'h00;
    foreach (pay[i]) c = c ^ pay[i];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    int guard = 0;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!ok && guard < 50) begin
      ok = (bus.in_ready === 1'b1);
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_byte: in_ready got 0 for 50 cycles, want 1");
    end
  endtask

  task automatic load(input int n, input logic [7:0] pay[$], input int min_gap,
                      input int max_gap, input bit noise);
    logic [15:0] hdr = 16'(n);
    pulse_start();
    send_byte(hdr[15:8], 0);
    send_byte(hdr[7:0], 0);
    foreach (pay[i]) begin
      start = noise && ($urandom_range(3, 0) == 0);
      send_byte(pay[i], $urandom_range(max_gap, min_gap));
      start = 1'b0;
    end
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(model_csum(pay), 0);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.im_we, busy, done, err, cpu_hold} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000001", {bus.in_ready, bus.im_we, busy, done, err, cpu_hold});
    end
    checks++;
    if (bus.im_addr !== '0 || bus.im_wdata !== 32'h0 || word_cnt !== '0) begin
      errors++;
      $display("FAIL reset_regs: addr %0d wdata %h cnt %0d want 0 0 0", bus.im_addr, bus.im_wdata, word_cnt);
    end
  endtask

  task automatic test_basic(input int gap);
    logic [7:0]  s[10] = '{8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    logic [7:0]  pay[$];
    logic [31:0] exp_w[$];
    for (int i = 2; i < 10; i++) pay.push_back(s[i]);
    model_words(pay, exp_w);
    caps.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(s[i], (i < 2) ? 0 : gap);
      if (i == 5 || i == 9) begin
        checks++;
        if (bus.im_we !== 1'b1 || bus.im_addr !== IM_AW'((i - 5) / 4) || bus.im_wdata !== exp_w[(i - 5) / 4]) begin
          errors++;
          $display("FAIL basic_write_latency gap%0d: we %b addr %0d data %h want 1 %0d %h",
                   gap, bus.im_we, bus.im_addr, bus.im_wdata, (i - 5) / 4, exp_w[(i - 5) / 4]);
        end
`ifndef IM_LOADER_CHECKSUM_EN
        if (i == 9) begin
          checks++;
          if ({done, cpu_hold} !== 2'b10 || word_cnt !== 11'd2) begin
            errors++;
            $display("FAIL basic_done_same_cycle: done %b hold %b cnt %0d want 1 0 2", done, cpu_hold, word_cnt);
          end
        end
`endif
      end
    end
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(model_csum(pay), 0);
`endif
    repeat (3) tick();
    checks++;
    if (caps.size() != 2 || caps[0].addr !== 0 || caps[0].data !== exp_w[0]
        || caps[1].addr !== 1 || caps[1].data !== exp_w[1]) begin
      errors++;
      $display("FAIL basic_writes gap%0d: got %0d writes, want 2 (%h %h)", gap, caps.size(), exp_w[0], exp_w[1]);
    end
    checks++;
    if ({done, err, cpu_hold, busy} !== 4'b1000 || word_cnt !== 11'd2) begin
      errors++;
      $display("FAIL basic_final gap%0d: done/err/hold/busy %b cnt %0d want 1000 2", gap, {done, err, cpu_hold, busy}, word_cnt);
    end
  endtask

  task automatic test_bad_header();
    logic [15:0] hdrs[2] = '{16'h0000, 16'h0401};
    foreach (hdrs[k]) begin
      logic [15:0] h = hdrs[k];
      caps.delete();
      pulse_start();
      send_byte(h[15:8], 0);
      send_byte(h[7:0], 0);
      checks++;
      if ({err, done, busy, cpu_hold, bus.in_ready} !== 5'b10010) begin
        errors++;
        $display("FAIL bad_header %h: err/done/busy/hold/rdy %b want 10010", h, {err, done, busy, cpu_hold, bus.in_ready});
      end
      repeat (4) tick();
      checks++;
      if (caps.size() != 0 || err !== 1'b1 || cpu_hold !== 1'b1) begin
        errors++;
        $display("FAIL bad_header_hold %h: writes %0d err %b hold %b want 0 1 1", h, caps.size(), err, cpu_hold);
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0]  pay[$];
    logic [7:0]  pay2[$];
    logic [31:0] exp_w[$];
    for (int i = 0; i < 40; i++) pay.push_back(8'($urandom));
    model_words(pay, exp_w);
    caps.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h0A, 0);
    for (int i = 0; i < 23; i++) send_byte(pay[i], 0);
    bus.in_valid = 1'b1; bus.in_data = pay[23]; reset = 1'b1;
    tick();
    reset = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if ({bus.in_ready, bus.im_we, busy, done, err, cpu_hold} !== 6'b000001
        || bus.im_addr !== '0 || bus.im_wdata !== 32'h0 || word_cnt !== '0) begin
      errors++;
      $display("FAIL midword_reset: flags %b addr %0d wdata %h cnt %0d want 000001 0 0 0",
               {bus.in_ready, bus.im_we, busy, done, err, cpu_hold}, bus.im_addr, bus.im_wdata, word_cnt);
    end
    repeat (3) tick();
    checks++;
    if (caps.size() != 5) begin
      errors++;
      $display("FAIL midword_write_count: got %0d want 5", caps.size());
    end else begin
      int bad = 0;
      foreach (caps[i]) if (caps[i].addr !== IM_AW'(i) || caps[i].data !== exp_w[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL midword_write_data: %0d bad entries want 0", bad);
      end
    end
    for (int i = 0; i < 4; i++) pay2.push_back(8'($urandom));
    model_words(pay2, exp_w);
    caps.delete();
    load(1, pay2, 0, 0, 1'b0);
    tick();
    checks++;
    if (caps.size() != 1 || caps[0].addr !== 0 || caps[0].data !== exp_w[0] || done !== 1'b1) begin
      errors++;
      $display("FAIL reload_after_reset: writes %0d done %b want 1 write of %h at 0 and done 1", caps.size(), done, exp_w[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int          n = $urandom_range(12, 1);
      int          bad = 0;
      int          guard = 0;
      logic [7:0]  pay[$];
      logic [31:0] exp_w[$];
      for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
      model_words(pay, exp_w);
      caps.delete();
      load(n, pay, 0, 2, 1'b1);
      while (done !== 1'b1 && guard < 10) begin tick(); guard++; end
      tick();
      checks++;
      if (caps.size() != n) begin
        errors++;
        $display("FAIL random_count it%0d: got %0d want %0d", it, caps.size(), n);
      end else begin
        foreach (caps[i]) if (caps[i].addr !== IM_AW'(i) || caps[i].data !== exp_w[i]) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL random_data it%0d: %0d bad entries want 0", it, bad);
        end
      end
      checks++;
      if ({done, cpu_hold, err} !== 3'b100 || word_cnt !== 11'(n)) begin
        errors++;
        $display("FAIL random_final it%0d: done/hold/err %b cnt %0d want 100 %0d", it, {done, cpu_hold, err}, word_cnt, n);
      end
    end
  endtask

  task automatic test_max();
    logic [7:0]  pay[$];
    int          bad = 0;
    for (int i = 0; i < IM_DEPTH; i++) begin
      pay.push_back(8'(i >> 24)); pay.push_back(8'(i >> 16));
      pay.push_back(8'(i >> 8));  pay.push_back(8'(i));
    end
    caps.delete();
    load(IM_DEPTH, pay, 0, 0, 1'b0);
    tick();
    checks++;
    if (caps.size() != IM_DEPTH || caps[caps.size()-1].addr !== IM_AW'(IM_DEPTH - 1)) begin
      errors++;
      $display("FAIL max_count: got %0d writes want %0d ending at addr %0d", caps.size(), IM_DEPTH, IM_DEPTH - 1);
    end
    foreach (caps[i]) if (caps[i].addr !== IM_AW'(i) || caps[i].data !== 32'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL max_data: %0d bad entries want 0", bad);
    end
    checks++;
    if (word_cnt !== 11'd1024 || done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL max_final: cnt %0d done %b hold %b want 1024 1 0", word_cnt, done, cpu_hold);
    end
  endtask

`ifdef IM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] s[6] = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] sums[2] = '{8'h08, 8'h09};
    foreach (sums[k]) begin
      caps.delete();
      pulse_start();
      foreach (s[i]) send_byte(s[i], 0);
      checks++;
      if (bus.im_we !== 1'b1 || bus.im_addr !== 0 || bus.im_wdata !== 32'h12345678 || done !== 1'b0) begin
        errors++;
        $display("FAIL csum_write_first: we %b addr %0d data %h done %b want 1 0 12345678 0",
                 bus.im_we, bus.im_addr, bus.im_wdata, done);
      end
      send_byte(sums[k], 0);
      checks++;
      if (done !== (k == 0) || err !== (k == 1) || caps.size() != 1) begin
        errors++;
        $display("FAIL csum_result %h: done %b err %b writes %0d want %b %b 1", sums[k], done, err, caps.size(), k == 0, k == 1);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_bad_header();
    test_reset_midword();
    test_random();
    test_max();
`ifdef IM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
